// File: rtl/dmem_bridge_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | dmem_bridge_if : memory-side valid/ready bus of the data bridge  |
// | Revision 1.0                                                     |
// +------------------------------------------------------------------+
interface dmem_bridge_if;
    logic        m_valid;
    logic        m_we;
    logic [31:0] m_addr;
    logic [3:0]  m_wstrb;
    logic [31:0] m_wdata;
    logic        m_ready;
    logic [31:0] m_rdata;

    modport master (
        output m_valid, m_we, m_addr, m_wstrb, m_wdata,
        input  m_ready, m_rdata
    );

    modport slave (
        input  m_valid, m_we, m_addr, m_wstrb, m_wdata,
        output m_ready, m_rdata
    );
endinterface
`default_nettype wire

// File: rtl/dmem_bridge.sv
`default_nettype none
// +------------------------------------------------------------------+
// | dmem_bridge : stalls the load/store stage while one memory access |
// | runs on a valid/ready bus, with a timeout. Revision 1.0           |
// +------------------------------------------------------------------+
module dmem_bridge #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  wire logic        clk,
    input  wire logic        rst_n,
    input  wire logic [31:0] req_addr,
    input  wire logic [3:0]  req_wstrb,
    input  wire logic [31:0] req_wdata,
    input  wire logic        req_rd,
    output logic             lsu_stall,
    output logic [31:0]      lsu_rdata,
    output logic             lsu_rvalid,
    output logic             bus_err,
    dmem_bridge_if.master    m
);

    localparam logic [15:0] TIMEOUT_LIMIT = 16'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state_q,  state_d;
    logic        valid_q,  valid_d;
    logic        we_q,     we_d;
    logic [31:0] addr_q,   addr_d;
    logic [3:0]  wstrb_q,  wstrb_d;
    logic [31:0] wdata_q,  wdata_d;
    logic [15:0] cnt_q,    cnt_d;
    logic [31:0] rdata_q,  rdata_d;
    logic        rvalid_q, rvalid_d;
    logic        err_q,    err_d;

    logic        req_present;
    logic        is_store;
    logic [15:0] cnt_inc;

    assign req_present = req_rd | (|req_wstrb);
    assign is_store    = |req_wstrb;
    assign cnt_inc     = cnt_q + 16'd1;

    always_comb begin
        state_d  = state_q;
        valid_d  = valid_q;
        we_d     = we_q;
        addr_d   = addr_q;
        wstrb_d  = wstrb_q;
        wdata_d  = wdata_q;
        cnt_d    = cnt_q;
        rdata_d  = rdata_q;
        rvalid_d = 1'b0;
        err_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_present) begin
                    state_d = BUSY;
                    valid_d = 1'b1;
                    // A store wins over a simultaneous load; loads present zero write data.
                    we_d    = is_store;
                    addr_d  = req_addr & 32'hFFFF_FFFC;
                    wstrb_d = req_wstrb;
                    wdata_d = req_wdata & {32{is_store}};
                    cnt_d   = 16'd0;
                end
            end
            BUSY: begin
                if (m.m_ready) begin
                    state_d = DONE;
                    valid_d = 1'b0;
                    if (!we_q) begin
                        rdata_d  = m.m_rdata;
                        rvalid_d = 1'b1;
                    end
                end else if (cnt_inc == TIMEOUT_LIMIT) begin
                    state_d = DONE;
                    valid_d = 1'b0;
                    cnt_d   = cnt_inc;
                    err_d   = 1'b1;
                    if (!we_q) begin
                        rdata_d  = 32'h0;
                        rvalid_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            DONE: begin
                // The request still visible here is the instruction just completed.
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            valid_q  <= 1'b0;
            we_q     <= 1'b0;
            addr_q   <= 32'h0;
            wstrb_q  <= 4'h0;
            wdata_q  <= 32'h0;
            cnt_q    <= 16'h0;
            rdata_q  <= 32'h0;
            rvalid_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            valid_q  <= valid_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wstrb_q  <= wstrb_d;
            wdata_q  <= wdata_d;
            cnt_q    <= cnt_d;
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
            err_q    <= err_d;
        end
    end

    // Stall rises in the capturing IDLE cycle so the pipeline holds the request.
    assign lsu_stall  = rst_n & (((state_q == IDLE) & req_present) | (state_q == BUSY));
    assign lsu_rdata  = rdata_q;
    assign lsu_rvalid = rvalid_q;
    assign bus_err    = err_q;

    assign m.m_valid = valid_q;
    assign m.m_we    = we_q;
    assign m.m_addr  = addr_q;
    assign m.m_wstrb = wstrb_q;
    assign m.m_wdata = wdata_q;

endmodule
`default_nettype wire

// File: tb/tb_dmem_bridge.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_dmem_bridge : directed bench with a load-result scoreboard     |
// | Revision 1.0                                                      |
// +------------------------------------------------------------------+
module tb_dmem_bridge;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] req_addr;
    logic [3:0]  req_wstrb;
    logic [31:0] req_wdata;
    logic        req_rd;
    logic        lsu_stall;
    logic [31:0] lsu_rdata;
    logic        lsu_rvalid;
    logic        bus_err;

    dmem_bridge_if bus ();

    dmem_bridge #(.TIMEOUT_CYCLES(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_addr   (req_addr),
        .req_wstrb  (req_wstrb),
        .req_wdata  (req_wdata),
        .req_rd     (req_rd),
        .lsu_stall  (lsu_stall),
        .lsu_rdata  (lsu_rdata),
        .lsu_rvalid (lsu_rvalid),
        .bus_err    (bus_err),
        .m          (bus.master)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] data;
        logic        err;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Every rvalid pulse must match the oldest outstanding load expectation.
    always @(negedge clk) begin
        if (lsu_rvalid === 1'b1) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_rvalid", 32'(lsu_rvalid), 32'd0);
            end else begin
                mon_e = sb_q.pop_front();
                chk("sb_rdata", lsu_rdata, mon_e.data);
                chk("sb_err", 32'(bus_err), 32'(mon_e.err));
            end
        end else if (bus_err === 1'b1) begin
            chk("unexpected_err", 32'(bus_err), 32'd0);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected end of test");
        $fatal(1, "watchdog expired");
    end

    logic [31:0] b2b_data [3];

    initial begin
        b2b_data[0] = 32'h1111_AAAA;
        b2b_data[1] = 32'h2222_BBBB;
        b2b_data[2] = 32'h3333_CCCC;

        // Reset with a load already waiting on the request lines.
        rst_n       = 1'b0;
        req_addr    = 32'h0000_1006;
        req_wstrb   = 4'h0;
        req_wdata   = 32'h0;
        req_rd      = 1'b1;
        bus.m_ready = 1'b0;
        bus.m_rdata = 32'h0;
        repeat (2) @(negedge clk);
        chk("rst_m_valid", 32'(bus.m_valid), 32'd0);
        chk("rst_m_we", 32'(bus.m_we), 32'd0);
        chk("rst_m_addr", bus.m_addr, 32'd0);
        chk("rst_m_wstrb", 32'(bus.m_wstrb), 32'd0);
        chk("rst_m_wdata", bus.m_wdata, 32'd0);
        chk("rst_stall", 32'(lsu_stall), 32'd0);
        chk("rst_rdata", lsu_rdata, 32'd0);
        chk("rst_rvalid", 32'(lsu_rvalid), 32'd0);
        chk("rst_err", 32'(bus_err), 32'd0);

        // Load, ready on the first BUSY cycle; first edge after release acts.
        bus.m_ready = 1'b1;
        bus.m_rdata = 32'hCAFE_F00D;
        rst_n = 1'b1;
        sb_q.push_back('{data: 32'hCAFE_F00D, err: 1'b0});
        #1;
        chk("ld_idle_stall", 32'(lsu_stall), 32'd1);
        @(negedge clk);
        chk("ld_busy_valid", 32'(bus.m_valid), 32'd1);
        chk("ld_busy_addr", bus.m_addr, 32'h0000_1004);
        chk("ld_busy_we", 32'(bus.m_we), 32'd0);
        chk("ld_busy_wstrb", 32'(bus.m_wstrb), 32'd0);
        chk("ld_busy_wdata", bus.m_wdata, 32'd0);
        chk("ld_busy_stall", 32'(lsu_stall), 32'd1);
        @(negedge clk);
        chk("ld_done_stall", 32'(lsu_stall), 32'd0);
        chk("ld_done_valid", 32'(bus.m_valid), 32'd0);
        chk("ld_done_rvalid", 32'(lsu_rvalid), 32'd1);
        req_rd = 1'b0;
        bus.m_ready = 1'b0;
        @(negedge clk);
        chk("ld_idle_rvalid", 32'(lsu_rvalid), 32'd0);
        chk("ld_idle_stall2", 32'(lsu_stall), 32'd0);

        // Store, ready arrives on the 4th BUSY cycle: the timeout boundary.
        req_addr  = 32'h0000_2002;
        req_wstrb = 4'b0100;
        req_wdata = 32'h00AB_0000;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("st_valid", 32'(bus.m_valid), 32'd1);
            chk("st_we", 32'(bus.m_we), 32'd1);
            chk("st_wstrb", 32'(bus.m_wstrb), 32'h4);
            chk("st_wdata", bus.m_wdata, 32'h00AB_0000);
            chk("st_addr", bus.m_addr, 32'h0000_2000);
            if (i == 3) bus.m_ready = 1'b1;
        end
        @(negedge clk);
        chk("st_done_valid", 32'(bus.m_valid), 32'd0);
        chk("st_done_err", 32'(bus_err), 32'd0);
        chk("st_done_rvalid", 32'(lsu_rvalid), 32'd0);
        chk("st_rdata_held", lsu_rdata, 32'hCAFE_F00D);
        req_wstrb   = 4'h0;
        req_wdata   = 32'h0;
        bus.m_ready = 1'b0;
        @(negedge clk);

        // Load that times out after 4 BUSY cycles.
        req_rd   = 1'b1;
        req_addr = 32'h0000_3000;
        sb_q.push_back('{data: 32'h0, err: 1'b1});
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("to_busy_valid", 32'(bus.m_valid), 32'd1);
        end
        @(negedge clk);
        chk("to_done_valid", 32'(bus.m_valid), 32'd0);
        chk("to_done_err", 32'(bus_err), 32'd1);
        chk("to_done_rvalid", 32'(lsu_rvalid), 32'd1);
        chk("to_done_rdata", lsu_rdata, 32'd0);
        req_rd = 1'b0;
        @(negedge clk);
        chk("to_idle_err", 32'(bus_err), 32'd0);

        // Load and store requested together: the store wins.
        req_rd      = 1'b1;
        req_wstrb   = 4'b1111;
        req_wdata   = 32'h1122_3344;
        req_addr    = 32'h0000_5008;
        bus.m_ready = 1'b1;
        bus.m_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        chk("both_we", 32'(bus.m_we), 32'd1);
        chk("both_wstrb", 32'(bus.m_wstrb), 32'hF);
        chk("both_wdata", bus.m_wdata, 32'h1122_3344);
        chk("both_addr", bus.m_addr, 32'h0000_5008);
        @(negedge clk);
        chk("both_rvalid", 32'(lsu_rvalid), 32'd0);
        chk("both_rdata", lsu_rdata, 32'd0);
        req_rd      = 1'b0;
        req_wstrb   = 4'h0;
        req_wdata   = 32'h0;
        bus.m_ready = 1'b0;
        @(negedge clk);

        // Reset pulled in the middle of BUSY.
        req_rd   = 1'b1;
        req_addr = 32'h0000_4000;
        @(negedge clk);
        chk("rb_busy_valid", 32'(bus.m_valid), 32'd1);
        req_rd = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("rb_async_valid", 32'(bus.m_valid), 32'd0);
        chk("rb_async_stall", 32'(lsu_stall), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rb_post_valid", 32'(bus.m_valid), 32'd0);
        chk("rb_post_addr", bus.m_addr, 32'd0);
        chk("rb_post_we", 32'(bus.m_we), 32'd0);
        chk("rb_post_stall", 32'(lsu_stall), 32'd0);
        chk("rb_post_rvalid", 32'(lsu_rvalid), 32'd0);
        chk("rb_post_err", 32'(bus_err), 32'd0);
        chk("rb_post_rdata", lsu_rdata, 32'd0);

        // Three back-to-back loads, request held high, ready tied high.
        bus.m_ready = 1'b1;
        req_rd      = 1'b1;
        for (int k = 0; k < 3; k++) begin
            req_addr = 32'h0000_0100 + 32'(4 * k);
            sb_q.push_back('{data: b2b_data[k], err: 1'b0});
            #1;
            chk("b2b_idle_stall", 32'(lsu_stall), 32'd1);
            chk("b2b_idle_rvalid", 32'(lsu_rvalid), 32'd0);
            @(negedge clk);
            chk("b2b_busy_addr", bus.m_addr, 32'h0000_0100 + 32'(4 * k));
            chk("b2b_busy_rvalid", 32'(lsu_rvalid), 32'd0);
            bus.m_rdata = b2b_data[k];
            @(negedge clk);
            chk("b2b_done_rvalid", 32'(lsu_rvalid), 32'd1);
            if (k == 2) req_rd = 1'b0;
            @(negedge clk);
        end
        bus.m_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("b2b_no_extra_valid", 32'(bus.m_valid), 32'd0);
        chk("sb_empty", 32'(sb_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
